// File: rtl/echo_image_scaler_if.sv
// Pixel-stream and image_mem read bundle for the echo image scaler.
// The master side drives the raster requests and RAM data; the slave is the scaler.
interface echo_image_scaler_if;
   logic       frame_start;
   logic       pix_req;
   logic [7:0] cam_pix;
   logic [9:0] mem_addr;
   logic [7:0] mem_rdata;
   logic [7:0] pix_out;
   logic       pix_out_vld;
   logic       in_win;
   logic       frame_done;

   modport master (
      output frame_start, pix_req, cam_pix, mem_rdata,
      input  mem_addr, pix_out, pix_out_vld, in_win, frame_done
   );

   modport slave (
      input  frame_start, pix_req, cam_pix, mem_rdata,
      output mem_addr, pix_out, pix_out_vld, in_win, frame_done
   );
endinterface

// File: rtl/echo_image_scaler.sv
// Echo image scaler: walks the active raster, reads the stored IMG_DIM x IMG_DIM image
// inside a fixed window, replicates each pixel SCALE times per axis, draws a 1-pixel
// border ring around the window and passes the camera pixel through elsewhere.
module echo_image_scaler #(
   parameter int         IMG_DIM    = 32,
   parameter int         SCALE      = 7,
   parameter int         H_ACTIVE   = 640,
   parameter int         V_ACTIVE   = 480,
   parameter int         WIN_X0     = 400,
   parameter int         WIN_Y0     = 128,
   parameter logic [7:0] BORDER_PIX = 8'hFF
) (
   input logic                clk,
   input logic                rst_n,
   echo_image_scaler_if.slave bus
);

   localparam int WIN = IMG_DIM * SCALE;
   localparam int CW  = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
   localparam int SW  = (SCALE > 1) ? $clog2(SCALE) : 1;

   typedef enum logic {StWaitFrame, StRun} state_t;

   state_t        r_state;
   logic [11:0]   r_hcnt, r_vcnt;
   logic [SW-1:0] r_sx, r_sy;
   logic [CW-1:0] r_col, r_row;

   // Stage 1 (T+1) and stage 2 (T+2) pipeline registers
   logic [9:0]    r_addr;
   logic          r1_vld, r1_hit, r1_border, r1_last;
   logic [7:0]    r1_cam;
   logic          r2_vld, r2_win, r2_done;
   logic [7:0]    r2_pix;

   logic [11:0]   w_h, w_v;
   logic [SW-1:0] w_sx, w_sy;
   logic [CW-1:0] w_col, w_row;
   logic          w_active, w_hx, w_vy, w_hit, w_border, w_last;
   logic          w_sx_last, w_sy_last, w_col_last, w_row_last;
   logic [9:0]    w_addr;
   int            w_hi, w_vi;

   // Effective position of the pixel sampled this cycle; frame_start forces it to (0,0)
   always_comb begin
      w_h        = bus.frame_start ? '0 : r_hcnt;
      w_v        = bus.frame_start ? '0 : r_vcnt;
      w_sx       = bus.frame_start ? '0 : r_sx;
      w_sy       = bus.frame_start ? '0 : r_sy;
      w_col      = bus.frame_start ? '0 : r_col;
      w_row      = bus.frame_start ? '0 : r_row;
      w_active   = bus.frame_start || (r_state == StRun);
      w_hi       = int'(w_h);
      w_vi       = int'(w_v);
      w_hx       = (w_hi >= WIN_X0) && (w_hi < WIN_X0 + WIN);
      w_vy       = (w_vi >= WIN_Y0) && (w_vi < WIN_Y0 + WIN);
      w_hit      = w_active && w_hx && w_vy;
      // Ring positions off-screen never match because the counters stay on-screen
      w_border   = w_active && !(w_hx && w_vy) &&
                   (w_hi >= WIN_X0 - 1) && (w_hi <= WIN_X0 + WIN) &&
                   (w_vi >= WIN_Y0 - 1) && (w_vi <= WIN_Y0 + WIN);
      w_sx_last  = (int'(w_sx) == SCALE - 1);
      w_sy_last  = (int'(w_sy) == SCALE - 1);
      w_col_last = (int'(w_col) == IMG_DIM - 1);
      w_row_last = (int'(w_row) == IMG_DIM - 1);
      w_last     = w_hit && w_sx_last && w_col_last && w_sy_last && w_row_last;
      w_addr     = 10'(int'(w_row) * IMG_DIM + int'(w_col));
   end

   // Frame FSM plus raster and scaling counters, advanced only by accepted pix_req
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StWaitFrame;
         r_hcnt  <= '0;
         r_vcnt  <= '0;
         r_sx    <= '0;
         r_sy    <= '0;
         r_col   <= '0;
         r_row   <= '0;
      end else begin
         if (bus.frame_start) begin
            r_state <= StRun;
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_col   <= '0;
            r_row   <= '0;
         end
         if (bus.pix_req && w_active) begin
            if (w_hi == H_ACTIVE - 1) begin
               r_hcnt <= '0;
               r_vcnt <= (w_vi == V_ACTIVE - 1) ? '0 : w_v + 12'd1;
            end else begin
               r_hcnt <= w_h + 12'd1;
            end
            if (w_hit) begin
               if (!w_sx_last) begin
                  r_sx <= w_sx + SW'(1);
               end else begin
                  r_sx <= '0;
                  if (!w_col_last) begin
                     r_col <= w_col + CW'(1);
                  end else begin
                     // Window line done: columns restart for the next line, rows step
                     r_col <= '0;
                     if (!w_sy_last) begin
                        r_sy <= w_sy + SW'(1);
                     end else begin
                        r_sy  <= '0;
                        r_row <= w_row_last ? '0 : w_row + CW'(1);
                     end
                  end
               end
            end
         end
      end
   end

   // Two-stage pixel pipeline: address/flags at T+1, composited outputs at T+2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr    <= '0;
         r1_vld    <= 1'b0;
         r1_hit    <= 1'b0;
         r1_border <= 1'b0;
         r1_last   <= 1'b0;
         r1_cam    <= '0;
         r2_vld    <= 1'b0;
         r2_win    <= 1'b0;
         r2_done   <= 1'b0;
         r2_pix    <= '0;
      end else begin
         r1_vld <= bus.pix_req;
         if (bus.pix_req) begin
            r1_cam    <= bus.cam_pix;
            r1_hit    <= w_hit;
            r1_border <= w_border;
            r1_last   <= w_last;
            if (w_hit) begin
               r_addr <= w_addr;
            end
         end
         r2_vld  <= r1_vld;
         r2_win  <= r1_vld && r1_hit;
         r2_done <= r1_vld && r1_last;
         if (r1_vld) begin
            r2_pix <= r1_border ? BORDER_PIX : r1_cam;
         end
      end
   end

   assign bus.mem_addr    = r_addr;
   // RAM data lands in the same cycle as the stage-2 flags, so it is selected by a
   // registered control rather than captured a second time.
   assign bus.pix_out     = r2_win ? bus.mem_rdata : r2_pix;
   assign bus.pix_out_vld = r2_vld;
   assign bus.in_win      = r2_win;
   assign bus.frame_done  = r2_done;

endmodule

// File: tb/tb_echo_image_scaler.sv
// Bench for echo_image_scaler on a reduced raster (4x4 image, x3 scale, 32x24 screen,
// window at (12,6)) so that several complete frames run in a few thousand cycles.
module tb_echo_image_scaler;
   localparam int D  = 4;
   localparam int S  = 3;
   localparam int H  = 32;
   localparam int V  = 24;
   localparam int WX = 12;
   localparam int WY = 6;
   localparam int W  = D * S;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   echo_image_scaler_if bus ();

   echo_image_scaler #(
      .IMG_DIM(D), .SCALE(S), .H_ACTIVE(H), .V_ACTIVE(V),
      .WIN_X0(WX), .WIN_Y0(WY), .BORDER_PIX(8'hFF)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // Synchronous image RAM model
   logic [7:0] mem [1024];
   always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int h; int v; int cyc;} req_t;
   req_t q[$];

   logic [7:0] cap_pix [V][H];
   logic       cap_win [V][H];
   int  cap_n, done_cnt, done_h, done_v, lat_err;
   bit  mon_en = 1'b0;
   int  n_chk = 0;
   int  n_err = 0;

   // Output monitor: pairs each valid pixel with its request and checks the 2-cycle latency
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.frame_done && !bus.pix_out_vld) lat_err++;
         if (bus.pix_out_vld) begin
            if (q.size() == 0) begin
               lat_err++;
            end else begin
               req_t r;
               r = q.pop_front();
               if (cyc != r.cyc + 2) lat_err++;
               cap_pix[r.v][r.h] = bus.pix_out;
               cap_win[r.v][r.h] = bus.in_win;
               cap_n++;
               if (bus.frame_done) begin
                  done_cnt++;
                  done_h = r.h;
                  done_v = r.v;
               end
            end
         end
      end
   end

   typedef struct {int h; int v; logic [7:0] pix; logic win;} vec_t;
   vec_t vec [15];

   task automatic chk(string name, int got, int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] cam_of(int h, int v);
      return 8'(64 + h + v);
   endfunction

   // Reference composite {in_win, pix} from coordinates, using division
   function automatic logic [8:0] model(int h, int v, bit run);
      bit inw, ring;
      int k;
      if (!run) return {1'b0, cam_of(h, v)};
      inw  = (h >= WX) && (h < WX + W) && (v >= WY) && (v < WY + W);
      ring = !inw && (h >= WX - 1) && (h <= WX + W) && (v >= WY - 1) && (v <= WY + W);
      if (inw) begin
         k = ((v - WY) / S) * D + (h - WX) / S;
         return {1'b1, mem[k]};
      end
      if (ring) return {1'b0, 8'hFF};
      return {1'b0, cam_of(h, v)};
   endfunction

   task automatic do_req(int h, int v, logic [7:0] cam, logic fs);
      @(posedge clk);
      #1;
      bus.frame_start = fs;
      bus.pix_req     = 1'b1;
      bus.cam_pix     = cam;
      q.push_back('{h: h, v: v, cyc: cyc});
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.pix_req     = 1'b0;
         bus.frame_start = 1'b0;
      end
   endtask

   task automatic clear_cap();
      cap_n    = 0;
      done_cnt = 0;
      done_h   = -1;
      done_v   = -1;
      lat_err  = 0;
      q.delete();
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++) begin
            cap_pix[y][x] = 8'h00;
            cap_win[y][x] = 1'b0;
         end
   endtask

   // Drive raster indices [first, last); optional leading frame_start and random gaps
   task automatic run_frame(bit gaps, bit start, int first, int last);
      if (start) begin
         @(posedge clk);
         #1;
         bus.frame_start = 1'b1;
         bus.pix_req     = 1'b0;
      end
      for (int i = first; i < last; i++) begin
         if (gaps) idle($urandom_range(0, 3));
         do_req(i % H, i / H, cam_of(i % H, i / H), 1'b0);
      end
      if (last == H * V) idle(4);
   endtask

   task automatic check_frame(string tag, bit run);
      int mism = 0;
      logic [8:0] e;
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++) begin
            e = model(x, y, run);
            if ({cap_win[y][x], cap_pix[y][x]} != e) mism++;
         end
      chk($sformatf("%s model_mismatches", tag), mism, 0);
      if (run) begin
         for (int i = 0; i < 15; i++)
            chk($sformatf("%s px(%0d,%0d)", tag, vec[i].h, vec[i].v),
                int'({cap_win[vec[i].v][vec[i].h], cap_pix[vec[i].v][vec[i].h]}),
                int'({vec[i].win, vec[i].pix}));
         chk($sformatf("%s done_h", tag), done_h, WX + W - 1);
         chk($sformatf("%s done_v", tag), done_v, WY + W - 1);
      end
      chk($sformatf("%s done_cnt", tag), done_cnt, run ? 1 : 0);
      chk($sformatf("%s latency_errs", tag), lat_err + q.size(), 0);
   endtask

   initial begin
      vec[0]  = '{12,  6, 8'h00, 1'b1};
      vec[1]  = '{14,  8, 8'h00, 1'b1};
      vec[2]  = '{15,  6, 8'h01, 1'b1};
      vec[3]  = '{12,  9, 8'h04, 1'b1};
      vec[4]  = '{23, 17, 8'h0F, 1'b1};
      vec[5]  = '{11, 10, 8'hFF, 1'b0};
      vec[6]  = '{24, 10, 8'hFF, 1'b0};
      vec[7]  = '{10, 10, 8'h54, 1'b0};
      vec[8]  = '{11,  5, 8'hFF, 1'b0};
      vec[9]  = '{24, 18, 8'hFF, 1'b0};
      vec[10] = '{12,  5, 8'hFF, 1'b0};
      vec[11] = '{18, 18, 8'hFF, 1'b0};
      vec[12] = '{ 0,  0, 8'h40, 1'b0};
      vec[13] = '{25, 10, 8'h63, 1'b0};
      vec[14] = '{18, 12, 8'h0A, 1'b1};
      for (int k = 0; k < 1024; k++) mem[k] = 8'(k);

      bus.frame_start = 1'b0;
      bus.pix_req     = 1'b0;
      bus.cam_pix     = 8'h00;
      clear_cap();
      repeat (3) @(posedge clk);
      #1;
      chk("reset pix_out", bus.pix_out, 0);
      chk("reset vld", bus.pix_out_vld, 0);
      chk("reset in_win", bus.in_win, 0);
      chk("reset mem_addr", bus.mem_addr, 0);
      chk("reset frame_done", bus.frame_done, 0);
      rst_n = 1'b1;
      idle(2);

      // Passthrough before any frame_start, one isolated request
      @(posedge clk);
      #1;
      bus.pix_req = 1'b1;
      bus.cam_pix = 8'h11;
      @(posedge clk);
      #1;
      bus.pix_req = 1'b0;
      chk("wait vld@+1", bus.pix_out_vld, 0);
      @(posedge clk);
      #1;
      chk("wait vld@+2", bus.pix_out_vld, 1);
      chk("wait pix@+2", bus.pix_out, 8'h11);
      chk("wait in_win@+2", bus.in_win, 0);
      @(posedge clk);
      #1;
      chk("wait vld@+3", bus.pix_out_vld, 0);

      // Whole frame without frame_start: everything is camera passthrough
      mon_en = 1'b1;
      clear_cap();
      run_frame(1'b0, 1'b0, 0, H * V);
      check_frame("waitframe", 1'b0);

      clear_cap();
      run_frame(1'b0, 1'b1, 0, H * V);
      check_frame("frame", 1'b1);

      clear_cap();
      run_frame(1'b1, 1'b1, 0, H * V);
      check_frame("gaps", 1'b1);

      // Mid-window restart: frame_start coincides with a pix_req, which becomes (0,0)
      clear_cap();
      run_frame(1'b0, 1'b1, 0, 12 * H + 5);
      do_req(0, 0, cam_of(0, 0), 1'b1);
      run_frame(1'b0, 1'b0, 1, H * V);
      check_frame("restart", 1'b1);
      chk("restart cap_n", cap_n, 12 * H + 5 + H * V);

      // Asynchronous reset with the pipeline full inside the window
      clear_cap();
      run_frame(1'b0, 1'b1, 0, 10 * H + 15);
      @(posedge clk);
      #2;
      rst_n       = 1'b0;
      bus.pix_req = 1'b0;
      #1;
      chk("midrst pix_out", bus.pix_out, 0);
      chk("midrst vld", bus.pix_out_vld, 0);
      chk("midrst in_win", bus.in_win, 0);
      chk("midrst mem_addr", bus.mem_addr, 0);
      chk("midrst frame_done", bus.frame_done, 0);
      clear_cap();
      idle(3);
      rst_n = 1'b1;
      idle(4);
      chk("postrst no_vld", cap_n + lat_err, 0);
      clear_cap();
      run_frame(1'b0, 1'b1, 0, H * V);
      check_frame("postrst", 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
